// File: rtl/pc_sequencer.sv
// pc_sequencer: small instruction sequencer.
//
// Fetches 16-bit instructions from an instruction memory over a simple
// req/ack handshake, decodes the opcode, and either hands the instruction
// to an external execute unit (valid/ready) or resolves a PC-relative
// jump or branch-if-zero locally. Each completed instruction advances the
// PC in a one-cycle UPDATE state and bumps the saturating retired counter.
// A halt opcode parks the sequencer in HALTED; a fetch that waits TIMEOUT
// cycles without an ack parks it in ERROR. start restarts from either
// parked state (and from IDLE).
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            one-cycle pulse, begins execution at start_addr
//   start_addr[7:0]  initial PC
//   imem_req         fetch request (FETCH state only)
//   imem_addr[7:0]   fetch address, always equal to pc
//   imem_ack         fetch data valid this cycle
//   imem_rdata[15:0] instruction: [15:12] opcode, [7:0] signed offset
//   zero_flag        datapath zero condition, sampled in DECODE
//   exec_valid       ir is presented to the execute unit (EXEC only)
//   exec_ready       execute unit accepts ir
//   pc[7:0]          program counter
//   ir[15:0]         instruction register
//   done             sequencer is in HALTED
//   busy             sequencer is in FETCH, DECODE, EXEC or UPDATE
//   err              sequencer is in ERROR (fetch timeout)
//   retired[15:0]    count of retired instructions, saturating
module pc_sequencer #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] BRZ_OP  = 4'hE,
  parameter logic [3:0] JMP_OP  = 4'hD,
  parameter int         TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_addr,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        zero_flag,
  output logic        exec_valid,
  input  logic        exec_ready,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [15:0] retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  // The wait counter starts at 0 on FETCH entry, so the last permitted
  // ack-less cycle is the one where it holds TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        taken_q, taken_d;

  logic [3:0]  op;

  assign op = ir_q[15:12];

  // Next-state and datapath logic for the whole sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    taken_d   = taken_q;

    case (state_q)
      IDLE, HALTED, ERROR: begin
        if (start) begin
          pc_d      = start_addr;
          retired_d = 16'd0;
          tmo_d     = 8'd0;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        // An ack on the final permitted cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      DECODE: begin
        taken_d = (op == JMP_OP) || ((op == BRZ_OP) && zero_flag);
        if (op == HALT_OP) begin
          state_d = HALTED;
        end else if ((op == BRZ_OP) || (op == JMP_OP)) begin
          state_d = UPDATE;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (exec_ready) begin
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        // An 8-bit add of the raw offset is the sign-extended add modulo 256.
        pc_d      = taken_q ? (pc_q + ir_q[7:0]) : (pc_q + 8'd1);
        retired_d = (retired_q == 16'hFFFF) ? retired_q : (retired_q + 16'd1);
        tmo_d     = 8'd0;
        state_d   = FETCH;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= 8'd0;
      ir_q      <= 16'd0;
      retired_q <= 16'd0;
      tmo_q     <= 8'd0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
      taken_q   <= taken_d;
    end
  end

  // Status and handshake outputs decode straight from the state register.
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign exec_valid = (state_q == EXEC);
  assign done       = (state_q == HALTED);
  assign err        = (state_q == ERROR);
  assign busy       = (state_q == FETCH) || (state_q == DECODE) ||
                      (state_q == EXEC)  || (state_q == UPDATE);
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Directed scenarios cover reset, wrap, branch, halt/restart, timeout and
// reset during EXEC. A randomized phase runs random programs against an
// instruction-level reference model; expected fetch/halt events go into a
// queue that a separate monitor pops whenever the DUT starts a fetch or halts.
module tb_pc_sequencer;

  localparam int TMO = 6;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        zero_flag;
  logic        exec_valid;
  logic        exec_ready;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        done;
  logic        busy;
  logic        err;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;   // 0 = fetch starts, 1 = halted
    int addr;
    int ret;
  } ev_t;

  ev_t exp_q[$];

  logic [15:0] mem  [256];
  logic        zmap [256];
  logic        resp_en = 1'b0;
  logic        mon_en  = 1'b0;
  int          wait_cnt = 0;

  pc_sequencer #(
    .HALT_OP(4'hF),
    .BRZ_OP (4'hE),
    .JMP_OP (4'hD),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .zero_flag (zero_flag),
    .exec_valid(exec_valid),
    .exec_ready(exec_ready),
    .pc        (pc),
    .ir        (ir),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_pc"}, pc, 0);
    check_output({tag, "_ir"}, ir, 0);
    check_output({tag, "_retired"}, retired, 0);
    check_output({tag, "_imem_req"}, imem_req, 0);
    check_output({tag, "_exec_valid"}, exec_valid, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  // Drives one instruction through a DUT sitting in FETCH with an immediate
  // ack and an immediately ready execute unit.
  task automatic apply_stimulus(input logic [15:0] instr, input logic zf);
    logic [3:0] op;
    op         = instr[15:12];
    zero_flag  = zf;
    imem_ack   = 1'b1;
    imem_rdata = instr;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    tick();
    if (op != 4'hF && op != 4'hE && op != 4'hD) begin
      check_output("exec_valid_in_exec", exec_valid, 1);
      check_output("ir_in_exec", ir, instr);
      tick();
      check_output("ir_stable_exec_wait", ir, instr);
      exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
    end
    if (op != 4'hF) begin
      tick();
    end
  endtask

  // Memory and execute-unit responder used in the randomized phase.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    exec_ready = 1'b0;
    zero_flag  = 1'b0;
    forever begin
      tick();
      if (resp_en) begin
        imem_ack   = 1'b0;
        exec_ready = 1'($urandom_range(0, 1));
        zero_flag  = zmap[imem_addr];
        if (imem_req) begin
          if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            wait_cnt   = $urandom_range(0, 3);
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops an expectation on each new fetch or halt.
  initial begin
    logic prev_req;
    logic prev_done;
    logic prev_err;
    ev_t  e;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req  = 1'b0;
        prev_done = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (mon_en && err && !prev_err) begin
          check_output("unexpected_err", err, 0);
        end
        if (mon_en && exp_q.size() > 0) begin
          if (imem_req && !prev_req) begin
            e = exp_q.pop_front();
            check_output("event_is_fetch", 0, e.kind);
            check_output("fetch_addr", imem_addr, e.addr);
            check_output("fetch_retired", retired, e.ret);
          end else if (done && !prev_done) begin
            e = exp_q.pop_front();
            check_output("event_is_halt", 1, e.kind);
            check_output("halt_pc", pc, e.addr);
            check_output("halt_retired", retired, e.ret);
            check_output("halt_busy", busy, 0);
          end
        end
        prev_req  = imem_req;
        prev_done = done;
        prev_err  = err;
      end
    end
  end

  // Instruction-level reference: walks the program and queues the expected
  // fetch addresses, retirement counts and the halt point.
  task automatic build_expectations(input int sa, input int max_fetch);
    int   p;
    int   r;
    int   off;
    logic [15:0] ins;
    ev_t  e;
    p = sa;
    r = 0;
    for (int n = 0; n < max_fetch; n++) begin
      e.kind = 0; e.addr = p; e.ret = r;
      exp_q.push_back(e);
      ins = mem[p];
      off = int'(ins[7:0]);
      if (off > 127) off = off - 256;
      if (ins[15:12] == 4'hF) begin
        e.kind = 1; e.addr = p; e.ret = r;
        exp_q.push_back(e);
        break;
      end
      if (ins[15:12] == 4'hD || (ins[15:12] == 4'hE && zmap[p])) begin
        p = (p + off + 256) % 256;
      end else begin
        p = (p + 1) % 256;
      end
      r++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 8'h00;
    #1;
    check_reset_state("reset");
    tick();
    rst = 1'b0;
    tick();

    // Straight-line instruction from 0x10.
    pulse_start(8'h10);
    check_output("busy_after_start", busy, 1);
    apply_stimulus(16'h0000, 1'b0);
    check_output("seq_pc", pc, 8'h11);
    check_output("seq_retired", retired, 1);

    // PC wrap.
    do_reset();
    pulse_start(8'hFF);
    apply_stimulus(16'h1234, 1'b0);
    check_output("wrap_pc", pc, 8'h00);
    check_output("wrap_retired", retired, 1);

    // Branch taken, with a start pulse while busy that must be ignored.
    do_reset();
    pulse_start(8'h05);
    pulse_start(8'h77);
    check_output("start_ignored_pc", pc, 8'h05);
    apply_stimulus(16'hE0FE, 1'b1);
    check_output("brz_taken_pc", pc, 8'h03);
    check_output("brz_taken_retired", retired, 1);

    // Branch not taken.
    do_reset();
    pulse_start(8'h05);
    apply_stimulus(16'hE0FE, 1'b0);
    check_output("brz_not_taken_pc", pc, 8'h06);

    // Halt, then restart and jump.
    do_reset();
    pulse_start(8'h20);
    apply_stimulus(16'hF000, 1'b0);
    check_output("halt_done", done, 1);
    check_output("halt_busy", busy, 0);
    check_output("halt_pc", pc, 8'h20);
    tick();
    tick();
    check_output("halt_pc_hold", pc, 8'h20);
    check_output("halt_retired_zero", retired, 0);
    pulse_start(8'h40);
    check_output("restart_pc", pc, 8'h40);
    check_output("restart_done", done, 0);
    apply_stimulus(16'hD005, 1'b0);
    check_output("jmp_pc", pc, 8'h45);
    check_output("jmp_retired", retired, 1);

    // Fetch timeout.
    do_reset();
    pulse_start(8'h30);
    for (int i = 1; i < TMO; i++) begin
      tick();
      check_output("tmo_err_early", err, 0);
      check_output("tmo_req_held", imem_req, 1);
    end
    tick();
    check_output("tmo_err", err, 1);
    check_output("tmo_req_drop", imem_req, 0);
    check_output("tmo_busy", busy, 0);
    pulse_start(8'h31);
    check_output("tmo_restart_err", err, 0);
    check_output("tmo_restart_pc", pc, 8'h31);

    // Asynchronous reset in the middle of an EXEC wait.
    do_reset();
    pulse_start(8'h50);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1ABC;
    tick();
    imem_ack   = 1'b0;
    tick();
    check_output("exec_wait_valid", exec_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    tick();
    rst = 1'b0;
    tick();

    // Randomized programs against the reference model.
    resp_en = 1'b1;
    mon_en  = 1'b1;
    for (int it = 0; it < 10; it++) begin
      int sa;
      for (int a = 0; a < 256; a++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 19);
        if (r == 0)      op = 4'hF;
        else if (r < 5)  op = 4'hD;
        else if (r < 9)  op = 4'hE;
        else             op = 4'($urandom_range(0, 12));
        mem[a]  = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
        zmap[a] = 1'($urandom_range(0, 1));
      end
      sa = $urandom_range(0, 255);
      build_expectations(sa, 25);
      pulse_start(8'(sa));
      for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
        tick();
      end
      check_output("trace_drained", exp_q.size(), 0);
      exp_q.delete();
      do_reset();
    end
    resp_en = 1'b0;
    mon_en  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
